// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: 40x30 cells of 16x16 glyphs with a blinking cursor.
// Three-stage pipeline from VGA timing inputs to registered RGB and syncs.
module text_pixel_gen #(
   parameter logic [11:0] FG_COLOR   = 12'hFFF,
   parameter logic [11:0] BG_COLOR   = 12'h000,
   parameter int          BLINK_LOG2 = 5
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [9:0]  X_IN,
   input  logic [9:0]  Y_IN,
   input  logic        VIDEO_ON_IN,
   input  logic        HS_IN,
   input  logic        VS_IN,
   output logic [10:0] TBUF_ADDR,
   input  logic [7:0]  TBUF_DATA,
   output logic [10:0] ROM_ADDR,
   output logic        ROM_EN,
   input  logic [15:0] ROM_DATA,
   input  logic        CURSOR_EN,
   input  logic [5:0]  CURSOR_COL,
   input  logic [4:0]  CURSOR_ROW,
   output logic [11:0] RGB,
   output logic        HS_OUT,
   output logic        VS_OUT,
   output logic        VIDEO_ON_OUT
);

   function automatic logic [11:0] pick_color(input logic video_on, input logic lit);
      if (!video_on)
         return 12'h000;
      return lit ? FG_COLOR : BG_COLOR;
   endfunction

   logic [5:0]  col;
   logic [4:0]  row;
   logic        cell_ok;
   logic        hit_p0;
   logic        unused_y;

   assign col      = X_IN[9:4];
   assign row      = Y_IN[8:4];
   assign unused_y = Y_IN[9];
   assign cell_ok  = (col < 6'd40) && (row < 5'd30);
   // An off-screen cursor can never match because the cell itself must be on-screen.
   assign hit_p0   = CURSOR_EN && cell_ok && (col == CURSOR_COL) && (row == CURSOR_ROW);

   assign TBUF_ADDR = cell_ok ? (11'(row) * 11'd40 + 11'(col)) : 11'd0;
   assign ROM_EN    = 1'b1;

   logic [BLINK_LOG2-1:0] frame_cnt;
   logic                  vs_prev;
   logic                  blink_visible;

   assign blink_visible = ~frame_cnt[BLINK_LOG2-1];

   always_ff @(posedge CLK) begin
      if (RST) begin
         frame_cnt <= '0;
         vs_prev   <= 1'b1;
      end else begin
         vs_prev <= VS_IN;
         if (vs_prev && !VS_IN)
            frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // Stage 1: text buffer read in flight
   logic [3:0] gx_p1;
   logic [3:0] gy_p1;
   logic       hit_p1;
   logic       von_p1;
   logic       hs_p1;
   logic       vs_p1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         gx_p1  <= 4'd0;
         gy_p1  <= 4'd0;
         hit_p1 <= 1'b0;
         von_p1 <= 1'b0;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
      end else begin
         gx_p1  <= X_IN[3:0];
         gy_p1  <= Y_IN[3:0];
         hit_p1 <= hit_p0;
         von_p1 <= VIDEO_ON_IN;
         hs_p1  <= HS_IN;
         vs_p1  <= VS_IN;
      end
   end

   // Glyph rows are stored bottom-first, so the row index is mirrored.
   assign ROM_ADDR = {TBUF_DATA[6:0], 4'd15 - gy_p1};

   // Stage 2: glyph ROM read in flight
   logic [3:0] gx_p2;
   logic       inv_p2;
   logic       hit_p2;
   logic       von_p2;
   logic       hs_p2;
   logic       vs_p2;

   always_ff @(posedge CLK) begin
      if (RST) begin
         gx_p2  <= 4'd0;
         inv_p2 <= 1'b0;
         hit_p2 <= 1'b0;
         von_p2 <= 1'b0;
         hs_p2  <= 1'b1;
         vs_p2  <= 1'b1;
      end else begin
         gx_p2  <= gx_p1;
         inv_p2 <= TBUF_DATA[7];
         hit_p2 <= hit_p1;
         von_p2 <= von_p1;
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
      end
   end

   logic pixel_p2;
   logic lit_p2;

   assign pixel_p2 = ROM_DATA[4'd15 - gx_p2];
   assign lit_p2   = pixel_p2 ^ inv_p2 ^ (hit_p2 & blink_visible);

   // Stage 3: registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         RGB          <= 12'h000;
         VIDEO_ON_OUT <= 1'b0;
         HS_OUT       <= 1'b1;
         VS_OUT       <= 1'b1;
      end else begin
         RGB          <= pick_color(von_p2, lit_p2);
         VIDEO_ON_OUT <= von_p2;
         HS_OUT       <= hs_p2;
         VS_OUT       <= vs_p2;
      end
   end

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen with behavioural text buffer and glyph ROM.
module tb_text_pixel_gen;

   logic        CLK = 1'b0;
   logic        RST;
   logic [9:0]  X_IN;
   logic [9:0]  Y_IN;
   logic        VIDEO_ON_IN;
   logic        HS_IN;
   logic        VS_IN;
   logic [10:0] TBUF_ADDR;
   logic [7:0]  TBUF_DATA;
   logic [10:0] ROM_ADDR;
   logic        ROM_EN;
   logic [15:0] ROM_DATA;
   logic        CURSOR_EN;
   logic [5:0]  CURSOR_COL;
   logic [4:0]  CURSOR_ROW;
   logic [11:0] RGB;
   logic        HS_OUT;
   logic        VS_OUT;
   logic        VIDEO_ON_OUT;

   int checks = 0;
   int errors = 0;

   logic [7:0] tbuf [0:1199];

   always #5 CLK = ~CLK;

   text_pixel_gen dut (
      .CLK(CLK), .RST(RST), .X_IN(X_IN), .Y_IN(Y_IN), .VIDEO_ON_IN(VIDEO_ON_IN),
      .HS_IN(HS_IN), .VS_IN(VS_IN), .TBUF_ADDR(TBUF_ADDR), .TBUF_DATA(TBUF_DATA),
      .ROM_ADDR(ROM_ADDR), .ROM_EN(ROM_EN), .ROM_DATA(ROM_DATA), .CURSOR_EN(CURSOR_EN),
      .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW), .RGB(RGB), .HS_OUT(HS_OUT),
      .VS_OUT(VS_OUT), .VIDEO_ON_OUT(VIDEO_ON_OUT)
   );

   function automatic logic [15:0] rom_row(input logic [10:0] a);
      case (a)
         11'h41D: return 16'h0380;
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge CLK) begin
      TBUF_DATA <= (TBUF_ADDR < 11'd1200) ? tbuf[TBUF_ADDR] : 8'h00;
      ROM_DATA  <= rom_row(ROM_ADDR);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic von);
      X_IN = x;
      Y_IN = y;
      VIDEO_ON_IN = von;
   endtask

   task automatic wait_pipe();
      repeat (3) @(negedge CLK);
   endtask

   task automatic vs_pulse(input int low_cycles);
      VS_IN = 1'b0;
      repeat (low_cycles) @(negedge CLK);
      VS_IN = 1'b1;
      @(negedge CLK);
   endtask

   logic [15:0] hs_pat;
   logic [15:0] vs_pat;
   logic [15:0] von_pat;

   initial begin
      for (int i = 0; i < 1200; i++) tbuf[i] = 8'h00;
      tbuf[0] = 8'h41;
      TBUF_DATA = 8'h00;
      ROM_DATA = 16'h0000;
      RST = 1'b1;
      set_pix(10'd0, 10'd0, 1'b1);
      HS_IN = 1'b0;
      VS_IN = 1'b1;
      CURSOR_EN = 1'b0;
      CURSOR_COL = 6'd0;
      CURSOR_ROW = 5'd0;
      repeat (3) @(negedge CLK);
      check_eq("rst_rgb", 32'(RGB), 32'h000);
      check_eq("rst_von", 32'(VIDEO_ON_OUT), 32'd0);
      check_eq("rst_hs", 32'(HS_OUT), 32'd1);
      check_eq("rst_vs", 32'(VS_OUT), 32'd1);
      check_eq("rom_en", 32'(ROM_EN), 32'd1);
      HS_IN = 1'b1;
      RST = 1'b0;

      // Glyph 'A' at cell (0,0)
      set_pix(10'd7, 10'd2, 1'b1);
      #1 check_eq("tbuf_addr_00", 32'(TBUF_ADDR), 32'd0);
      @(negedge CLK);
      check_eq("rom_addr_A", 32'(ROM_ADDR), 32'h41D);
      repeat (2) @(negedge CLK);
      check_eq("rgb_A_x7", 32'(RGB), 32'hFFF);
      set_pix(10'd0, 10'd2, 1'b1);
      wait_pipe();
      check_eq("rgb_A_x0", 32'(RGB), 32'h000);
      tbuf[0] = 8'hC1;
      wait_pipe();
      check_eq("rgb_inv_x0", 32'(RGB), 32'hFFF);
      set_pix(10'd7, 10'd2, 1'b1);
      wait_pipe();
      check_eq("rgb_inv_x7", 32'(RGB), 32'h000);
      tbuf[0] = 8'h41;

      // Address mapping and video gating
      set_pix(10'd639, 10'd479, 1'b1);
      #1 check_eq("tbuf_addr_last", 32'(TBUF_ADDR), 32'd1199);
      set_pix(10'd80, 10'd48, 1'b1);
      #1 check_eq("tbuf_addr_125", 32'(TBUF_ADDR), 32'd125);
      set_pix(10'd700, 10'd48, 1'b1);
      #1 check_eq("tbuf_addr_off", 32'(TBUF_ADDR), 32'd0);
      @(negedge CLK);
      set_pix(10'd7, 10'd2, 1'b0);
      wait_pipe();
      check_eq("rgb_video_off", 32'(RGB), 32'h000);

      // Sync and video-on delayed exactly three cycles
      hs_pat  = 16'hDE7B;
      vs_pat  = 16'hF3BD;
      von_pat = 16'h0FF0;
      for (int i = 0; i < 19; i++) begin
         if (i >= 3) begin
            check_eq("hs_delay", 32'(HS_OUT), 32'(hs_pat[i-3]));
            check_eq("vs_delay", 32'(VS_OUT), 32'(vs_pat[i-3]));
            check_eq("von_delay", 32'(VIDEO_ON_OUT), 32'(von_pat[i-3]));
            check_eq("rgb_delay", 32'(RGB), von_pat[i-3] ? 32'hFFF : 32'h000);
         end
         if (i < 16) begin
            HS_IN = hs_pat[i];
            VS_IN = vs_pat[i];
            VIDEO_ON_IN = von_pat[i];
         end
         @(negedge CLK);
      end

      // Mid-line reset
      set_pix(10'd7, 10'd2, 1'b1);
      HS_IN = 1'b0;
      VS_IN = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check_eq("midrst_rgb", 32'(RGB), 32'h000);
      check_eq("midrst_von", 32'(VIDEO_ON_OUT), 32'd0);
      check_eq("midrst_hs", 32'(HS_OUT), 32'd1);
      check_eq("midrst_vs", 32'(VS_OUT), 32'd1);
      HS_IN = 1'b1;
      VS_IN = 1'b1;
      RST = 1'b0;

      // Cursor blink over a blank cell at (5,3)
      CURSOR_EN = 1'b1;
      CURSOR_COL = 6'd5;
      CURSOR_ROW = 5'd3;
      set_pix(10'd80, 10'd48, 1'b1);
      wait_pipe();
      check_eq("cursor_f0", 32'(RGB), 32'hFFF);
      vs_pulse(5);
      for (int i = 1; i < 15; i++) vs_pulse(1);
      wait_pipe();
      check_eq("cursor_f15", 32'(RGB), 32'hFFF);
      vs_pulse(1);
      wait_pipe();
      check_eq("cursor_f16", 32'(RGB), 32'h000);
      for (int i = 0; i < 15; i++) vs_pulse(1);
      wait_pipe();
      check_eq("cursor_f31", 32'(RGB), 32'h000);
      vs_pulse(1);
      wait_pipe();
      check_eq("cursor_f32", 32'(RGB), 32'hFFF);

      CURSOR_EN = 1'b0;
      wait_pipe();
      check_eq("cursor_off", 32'(RGB), 32'h000);

      // Off-screen cursor never hits
      CURSOR_EN = 1'b1;
      CURSOR_COL = 6'd45;
      set_pix(10'd720, 10'd48, 1'b1);
      wait_pipe();
      check_eq("cursor_offscreen", 32'(RGB), 32'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
